// File: rtl/bus_sys_mem_copy_master_if.sv
// Bus bundle for bus_sys_mem_copy_master.
// Carries the command handshake, the status outputs and the memory port.
//   master modport : copy engine view (drives memory strobes and status)
//   slave modport  : command issuer / memory view
interface bus_sys_mem_copy_master_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_W-1:0]     cmd_src;
    logic [ADDR_W-1:0]     cmd_dst;
    logic [ADDR_W-1:0]     cmd_len;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [ADDR_W-1:0]     address;
    logic                  chipselect;
    logic                  write;
    logic [DATA_W/8-1:0]   byteenable;
    logic [DATA_W-1:0]     writedata;
    logic                  clken;
    logic                  reset_req;
    logic [DATA_W-1:0]     readdata;
    logic                  miscompare;

    modport master (
        input  cmd_valid, cmd_src, cmd_dst, cmd_len, readdata,
        output cmd_ready, busy, done, err, address, chipselect, write,
               byteenable, writedata, clken, reset_req, miscompare
    );

    modport slave (
        output cmd_valid, cmd_src, cmd_dst, cmd_len, readdata,
        input  cmd_ready, busy, done, err, address, chipselect, write,
               byteenable, writedata, clken, reset_req, miscompare
    );
endinterface

// File: rtl/bus_sys_mem_copy_master.sv
// Word-by-word memory copy engine on a latency-1 memory port.
// A command (src, dst, len) is range- and overlap-checked on accept, then each
// word is read (RD), captured (CAP) and written (WR) in ascending order.
// Optional macro BUS_SYS_COPY_VERIFY_EN adds a read-back (RDV) and compare
// (CMP) per word, setting the sticky miscompare flag on a difference.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : master modport of bus_sys_mem_copy_master_if (command handshake,
//           busy/done/err/miscompare status, memory address/strobes/data)
module bus_sys_mem_copy_master #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 163840
) (
    input  logic                              clk,
    input  logic                              reset,
    bus_sys_mem_copy_master_if.master         bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_CAP  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
`ifdef BUS_SYS_COPY_VERIFY_EN
    localparam logic [2:0] ST_RDV  = 3'd5;
    localparam logic [2:0] ST_CMP  = 3'd6;
    localparam logic [2:0] ST_LAST = ST_CMP;
`else
    localparam logic [2:0] ST_LAST = ST_WR;
`endif

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

    logic [2:0]        state;
    logic              err_r;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] hold;

    logic              accept;
    logic              last_word;
    logic              range_err;
    logic [ADDR_W:0]   src_end;
    logic [ADDR_W:0]   dst_end;

    assign accept    = bus.cmd_valid && bus.cmd_ready;
    assign last_word = (cnt == ADDR_W'(1));

    // One extra bit so end addresses never wrap before the depth compare.
    assign src_end   = {1'b0, bus.cmd_src} + {1'b0, bus.cmd_len};
    assign dst_end   = {1'b0, bus.cmd_dst} + {1'b0, bus.cmd_len};
    // A forward-overlapping destination would read words already overwritten.
    assign range_err = (src_end > DEPTH_LIM) || (dst_end > DEPTH_LIM) ||
                       ((bus.cmd_dst > bus.cmd_src) && ({1'b0, bus.cmd_dst} < src_end));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            err_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (bus.cmd_len == '0) begin
                            err_r <= 1'b0;
                            state <= ST_DONE;
                        end else if (range_err) begin
                            err_r <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            err_r <= 1'b0;
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD:   state <= ST_CAP;
                ST_CAP:  state <= ST_WR;
`ifdef BUS_SYS_COPY_VERIFY_EN
                ST_WR:   state <= ST_RDV;
                ST_RDV:  state <= ST_CMP;
                ST_CMP:  state <= last_word ? ST_DONE : ST_RD;
`else
                ST_WR:   state <= last_word ? ST_DONE : ST_RD;
`endif
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are reloaded on every accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            src_ptr <= bus.cmd_src;
            dst_ptr <= bus.cmd_dst;
            cnt     <= bus.cmd_len;
        end else if (state == ST_LAST) begin
            src_ptr <= src_ptr + ADDR_W'(1);
            dst_ptr <= dst_ptr + ADDR_W'(1);
            cnt     <= cnt - ADDR_W'(1);
        end
        if (state == ST_CAP) begin
            hold <= bus.readdata;
        end
    end

`ifdef BUS_SYS_COPY_VERIFY_EN
    logic mc_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mc_r <= 1'b0;
        end else if (accept) begin
            mc_r <= 1'b0;
        end else if ((state == ST_CMP) && (bus.readdata != hold)) begin
            mc_r <= 1'b1;
        end
    end

    assign bus.miscompare = reset && mc_r;
`else
    assign bus.miscompare = 1'b0;
`endif

    // Outputs are gated by reset so an access in flight is dropped at once,
    // before the memory can sample it on the reset edge.
    always_comb begin
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        if (reset) begin
            case (state)
                ST_RD: begin
                    bus.chipselect = 1'b1;
                    bus.address    = src_ptr;
                end
                ST_WR: begin
                    bus.chipselect = 1'b1;
                    bus.write      = 1'b1;
                    bus.address    = dst_ptr;
                    bus.writedata  = hold;
                end
`ifdef BUS_SYS_COPY_VERIFY_EN
                ST_RDV: begin
                    bus.chipselect = 1'b1;
                    bus.address    = dst_ptr;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready  = reset && (state == ST_IDLE);
    assign bus.busy       = reset && (state != ST_IDLE);
    assign bus.done       = reset && (state == ST_DONE);
    assign bus.err        = bus.done && err_r;
    assign bus.byteenable = '1;
    assign bus.clken      = 1'b1;
    assign bus.reset_req  = 1'b0;

endmodule

// File: tb/tb_bus_sys_mem_copy_master.sv
// Directed bench for bus_sys_mem_copy_master with a latency-1 memory model.
// Honors BUS_SYS_COPY_VERIFY_EN for per-word cycle counts and the verify test.
module tb_bus_sys_mem_copy_master;
    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 163840;
`ifdef BUS_SYS_COPY_VERIFY_EN
    localparam int CYC  = 5;
    localparam int CS_W = 3;
`else
    localparam int CYC  = 3;
    localparam int CS_W = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    logic corrupt;
    logic pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;
    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_sys_mem_copy_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    bus_sys_mem_copy_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory: synchronous write, registered read (data valid the next cycle).
    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (bus.chipselect && bus.write && (bus.address < MEM_DEPTH))
            mem[bus.address] <= bus.writedata;
        if (bus.address < MEM_DEPTH)
            bus.readdata <= mem[bus.address] ^ (corrupt ? 32'h00FF_0000 : 32'h0);
    end

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                         input logic [ADDR_W-1:0] l);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_src = s; bus.cmd_dst = d; bus.cmd_len = l;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Issues a command and observes until done; k counts cycles after accept.
    task automatic run_cmd(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input logic [ADDR_W-1:0] l, output int lat, output logic e,
                           output int cs, output logic rdy_k2, output logic [ADDR_W-1:0] a_k1,
                           output logic [ADDR_W-1:0] a_k3, output logic we_k3,
                           output logic [DATA_W-1:0] wd_k3);
        lat = 0; e = 1'bx; cs = 0; rdy_k2 = 1'bx; a_k1 = 'x; a_k3 = 'x; we_k3 = 1'bx; wd_k3 = 'x;
        issue(s, d, l);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus.chipselect) cs++;
            if (k == 1) a_k1 = bus.address;
            if (k == 2) rdy_k2 = bus.cmd_ready;
            if (k == 3) begin a_k3 = bus.address; we_k3 = bus.write; wd_k3 = bus.writedata; end
            if (bus.done) begin lat = k; e = bus.err; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got=%b exp=0", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL rst_done_err got=%b%b exp=00", bus.done, bus.err); end
        checks++; if (bus.chipselect !== 1'b0 || bus.write !== 1'b0) begin errors++; $display("FAIL rst_strobes got=%b%b exp=00", bus.chipselect, bus.write); end
        checks++; if (bus.address !== '0 || bus.writedata !== '0) begin errors++; $display("FAIL rst_addr_data got=%h/%h exp=0/0", bus.address, bus.writedata); end
        checks++; if (bus.miscompare !== 1'b0) begin errors++; $display("FAIL rst_miscompare got=%b exp=0", bus.miscompare); end
        checks++; if (bus.clken !== 1'b1 || bus.reset_req !== 1'b0) begin errors++; $display("FAIL rst_clken got=%b/%b exp=1/0", bus.clken, bus.reset_req); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%b exp=1", bus.cmd_ready); end
    endtask

    task automatic test_copy();
        int lat, cs; logic e, r2, we3; logic [ADDR_W-1:0] a1, a3; logic [DATA_W-1:0] wd3;
        for (int i = 0; i < 4; i++) poke(18'h100 + 18'(i), 32'hCAFE_00A0 + 32'(i));
        run_cmd(18'h100, 18'h200, 18'd4, lat, e, cs, r2, a1, a3, we3, wd3);
        checks++; if (lat !== 4*CYC+1) begin errors++; $display("FAIL copy_done_cycle got=%0d exp=%0d", lat, 4*CYC+1); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL copy_err got=%b exp=0", e); end
        checks++; if (cs !== 4*CS_W) begin errors++; $display("FAIL copy_cs_cycles got=%0d exp=%0d", cs, 4*CS_W); end
        checks++; if (a1 !== 18'h100) begin errors++; $display("FAIL copy_first_rd_addr got=%h exp=100", a1); end
        checks++; if (r2 !== 1'b0) begin errors++; $display("FAIL copy_ready_busy got=%b exp=0", r2); end
        checks++; if (a3 !== 18'h200 || we3 !== 1'b1 || wd3 !== 32'hCAFE_00A0) begin errors++; $display("FAIL copy_first_wr got=%h/%b/%h exp=200/1/cafe00a0", a3, we3, wd3); end
        checks++; if (bus.byteenable !== 4'hF) begin errors++; $display("FAIL copy_byteenable got=%h exp=f", bus.byteenable); end
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL copy_ready_after got=%b/%b exp=1/0", bus.cmd_ready, bus.busy); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem[18'h200 + 18'(i)] !== 32'hCAFE_00A0 + 32'(i)) begin errors++; $display("FAIL copy_data[%0d] got=%h exp=%h", i, mem[18'h200 + 18'(i)], 32'hCAFE_00A0 + 32'(i)); end
        end
    endtask

    task automatic test_len_zero();
        int lat, cs; logic e, r2, we3; logic [ADDR_W-1:0] a1, a3; logic [DATA_W-1:0] wd3;
        run_cmd(18'h050, 18'h060, 18'd0, lat, e, cs, r2, a1, a3, we3, wd3);
        checks++; if (lat !== 1 || e !== 1'b0) begin errors++; $display("FAIL len0_done got=%0d/%b exp=1/0", lat, e); end
        repeat (2) begin @(negedge clk); if (bus.chipselect) cs++; end
        checks++; if (cs !== 0) begin errors++; $display("FAIL len0_cs got=%0d exp=0", cs); end
    endtask

    task automatic test_range();
        int lat, cs; logic e, r2, we3; logic [ADDR_W-1:0] a1, a3; logic [DATA_W-1:0] wd3;
        poke(18'h27FFE, 32'h1111_0001);
        poke(18'h300, 32'h5A5A_0300);
        run_cmd(18'h27FFE, 18'h300, 18'd3, lat, e, cs, r2, a1, a3, we3, wd3);
        checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL range_err got=%0d/%b exp=1/1", lat, e); end
        checks++; if (cs !== 0 || mem[18'h300] !== 32'h5A5A_0300) begin errors++; $display("FAIL range_untouched got=%0d/%h exp=0/5a5a0300", cs, mem[18'h300]); end
        // Exactly at the end of memory is legal: 0x27FFE + 2 == depth.
        poke(18'h27FFF, 32'h1111_0002);
        run_cmd(18'h27FFE, 18'h310, 18'd2, lat, e, cs, r2, a1, a3, we3, wd3);
        checks++; if (lat !== 2*CYC+1 || e !== 1'b0 || mem[18'h311] !== 32'h1111_0002) begin errors++; $display("FAIL range_edge got=%0d/%b/%h exp=%0d/0/11110002", lat, e, mem[18'h311], 2*CYC+1); end
    endtask

    task automatic test_overlap();
        int lat, cs; logic e, r2, we3; logic [ADDR_W-1:0] a1, a3; logic [DATA_W-1:0] wd3;
        logic [DATA_W-1:0] exp_v [0:5];
        for (int i = 0; i < 6; i++) poke(18'h10 + 18'(i), 32'hB0B0_0000 + 32'(i));
        run_cmd(18'h10, 18'h12, 18'd4, lat, e, cs, r2, a1, a3, we3, wd3);
        checks++; if (lat !== 1 || e !== 1'b1 || cs !== 0) begin errors++; $display("FAIL overlap_fwd got=%0d/%b/%0d exp=1/1/0", lat, e, cs); end
        run_cmd(18'h12, 18'h10, 18'd4, lat, e, cs, r2, a1, a3, we3, wd3);
        checks++; if (lat !== 4*CYC+1 || e !== 1'b0) begin errors++; $display("FAIL overlap_back got=%0d/%b exp=%0d/0", lat, e, 4*CYC+1); end
        exp_v[0] = 32'hB0B0_0002; exp_v[1] = 32'hB0B0_0003; exp_v[2] = 32'hB0B0_0004;
        exp_v[3] = 32'hB0B0_0005; exp_v[4] = 32'hB0B0_0004; exp_v[5] = 32'hB0B0_0005;
        for (int i = 0; i < 6; i++) begin
            checks++; if (mem[18'h10 + 18'(i)] !== exp_v[i]) begin errors++; $display("FAIL overlap_data[%0d] got=%h exp=%h", i, mem[18'h10 + 18'(i)], exp_v[i]); end
        end
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 5; i++) begin
            poke(18'h400 + 18'(i), 32'hC0C0_0000 + 32'(i));
            poke(18'h500 + 18'(i), 32'hDEAD_0000 + 32'(i));
        end
        issue(18'h400, 18'h500, 18'd5);
        for (int k = 1; k <= 2*CYC+3; k++) @(negedge clk);
        checks++; if (bus.write !== 1'b1 || bus.address !== 18'h502) begin errors++; $display("FAIL abort_in_wr2 got=%b/%h exp=1/502", bus.write, bus.address); end
        reset = 1'b0;
        #1;
        checks++; if (bus.chipselect !== 1'b0) begin errors++; $display("FAIL abort_cs_now got=%b exp=0", bus.chipselect); end
        @(negedge clk);
        checks++; if (bus.chipselect !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_next got=%b/%b exp=0/0", bus.chipselect, bus.busy); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b/%b exp=1/0", bus.cmd_ready, bus.busy); end
        for (int i = 0; i < 5; i++) begin
            logic [DATA_W-1:0] ev;
            ev = (i < 2) ? 32'hC0C0_0000 + 32'(i) : 32'hDEAD_0000 + 32'(i);
            checks++; if (mem[18'h500 + 18'(i)] !== ev) begin errors++; $display("FAIL abort_data[%0d] got=%h exp=%h", i, mem[18'h500 + 18'(i)], ev); end
        end
    endtask

    task automatic test_verify();
        for (int i = 0; i < 3; i++) poke(18'h600 + 18'(i), 32'hD0D0_0000 + 32'(i));
`ifdef BUS_SYS_COPY_VERIFY_EN
        begin
            int lat;
            lat = 0;
            issue(18'h600, 18'h700, 18'd3);
            for (int k = 1; k <= 100; k++) begin
                @(negedge clk);
                corrupt = (k == 9);   // RDV of word 1; corrupted data arrives in CMP
                if (bus.done) begin lat = k; break; end
            end
            corrupt = 1'b0;
            checks++; if (lat !== 16) begin errors++; $display("FAIL verify_done_cycle got=%0d exp=16", lat); end
            checks++; if (bus.miscompare !== 1'b1) begin errors++; $display("FAIL verify_mc_at_done got=%b exp=1", bus.miscompare); end
            repeat (2) @(negedge clk);
            checks++; if (bus.miscompare !== 1'b1) begin errors++; $display("FAIL verify_mc_sticky got=%b exp=1", bus.miscompare); end
        end
`else
        begin
            int lat, cs; logic e, r2, we3; logic [ADDR_W-1:0] a1, a3; logic [DATA_W-1:0] wd3;
            run_cmd(18'h600, 18'h700, 18'd3, lat, e, cs, r2, a1, a3, we3, wd3);
            @(negedge clk);
            checks++; if (bus.miscompare !== 1'b0 || lat !== 10) begin errors++; $display("FAIL noverify_mc got=%b/%0d exp=0/10", bus.miscompare, lat); end
        end
`endif
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem[18'h700 + 18'(i)] !== 32'hD0D0_0000 + 32'(i)) begin errors++; $display("FAIL verify_data[%0d] got=%h exp=%h", i, mem[18'h700 + 18'(i)], 32'hD0D0_0000 + 32'(i)); end
        end
    endtask

    initial begin
        reset = 1'b0; corrupt = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        bus.cmd_valid = 1'b0; bus.cmd_src = '0; bus.cmd_dst = '0; bus.cmd_len = '0;
        test_reset();
        test_copy();
        test_len_zero();
        test_range();
        test_overlap();
        test_reset_abort();
        test_verify();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
